// File: rtl/ddp_pkg.sv
// Shared DDP ring packet layout helpers and operand-side constants.
// Field positions for the {SINGLE,LR,TAG,DATA} and {SINGLE,TAG,DATA_L,DATA_R} formats.
package ddp_pkg;

    localparam logic LR_LEFT  = 1'b0;
    localparam logic LR_RIGHT = 1'b1;

    function automatic int pkt_w(int tag_w, int data_w);
        return 2 + tag_w + data_w;
    endfunction

    function automatic int out_w(int tag_w, int data_w);
        return 1 + tag_w + 2 * data_w;
    endfunction

    function automatic int in_single_pos(int tag_w, int data_w);
        return 1 + tag_w + data_w;
    endfunction

    function automatic int in_lr_pos(int tag_w, int data_w);
        return tag_w + data_w;
    endfunction

    function automatic int in_tag_lsb(int data_w);
        return data_w;
    endfunction

    function automatic int out_tag_lsb(int data_w);
        return 2 * data_w;
    endfunction

    function automatic int out_dl_lsb(int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/ddp_match_cam.sv
// Matching memory: DEPTH tagged operand slots with parallel compare,
// lowest-free allocation and single-entry invalidate.
module ddp_match_cam
    import ddp_pkg::*;
#(
    parameter  int TAG_W  = 12,
    parameter  int DATA_W = 24,
    parameter  int DEPTH  = 8,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [TAG_W-1:0]  lk_tag,
    input  logic              lk_lr,
    output logic              hit,
    output logic              dup,
    output logic [IDX_W-1:0]  hit_idx,
    output logic [DATA_W-1:0] hit_data,
    input  logic              wr_en,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic              wr_lr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              inv_en,
    input  logic [IDX_W-1:0]  inv_idx
);

    logic [DEPTH-1:0]  valid;
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [DEPTH-1:0]  lr_q;
    logic [DATA_W-1:0] data_q [DEPTH];

    logic             match_any;
    logic [IDX_W-1:0] match_idx;
    logic             free_any;
    logic [IDX_W-1:0] free_idx;

    // Tags are unique in the memory, so at most one slot can match.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && tag_q[i] == lk_tag) begin
                match_any = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign hit      = match_any && (lr_q[match_idx] != lk_lr);
    assign dup      = match_any && (lr_q[match_idx] == lk_lr);
    assign hit_idx  = match_idx;
    assign hit_data = data_q[match_idx];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            valid <= '0;
        end else begin
            if (inv_en) begin
                valid[inv_idx] <= 1'b0;
            end
            if (wr_en && free_any) begin
                valid[free_idx]  <= 1'b1;
                tag_q[free_idx]  <= wr_tag;
                lr_q[free_idx]   <= wr_lr;
                data_q[free_idx] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/ddp_match_join.sv
// DDP ring operand-matching join stage between the M and PS stages.
// Pairs left/right operands by tag; single-operand packets bypass the memory.
module ddp_match_join
    import ddp_pkg::*;
#(
    parameter  int TAG_W  = 12,
    parameter  int DATA_W = 24,
    parameter  int DEPTH  = 8,
    localparam int PKT_W  = pkt_w(TAG_W, DATA_W),
    localparam int OUT_W  = out_w(TAG_W, DATA_W),
    localparam int OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic             CP,
    input  logic             MR,
    input  logic             Send_in,
    output logic             Ack_out,
    input  logic [PKT_W-1:0] PACKET_IN,
    output logic             Send_out,
    input  logic             Ack_in,
    output logic [OUT_W-1:0] PACKET_OUT,
    input  logic             CLR,
    output logic [OCC_W-1:0] OCC,
    output logic             ERR
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int SGL_P = in_single_pos(TAG_W, DATA_W);
    localparam int LR_P  = in_lr_pos(TAG_W, DATA_W);
    localparam int TAG_L = in_tag_lsb(DATA_W);
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] ONE  = OCC_W'(1);

    logic              in_single;
    logic              in_lr;
    logic [TAG_W-1:0]  in_tag;
    logic [DATA_W-1:0] in_data;

    logic              hit;
    logic              dup;
    logic [IDX_W-1:0]  hit_idx;
    logic [DATA_W-1:0] hit_data;

    logic              out_free;
    logic              ack_ok;
    logic              xfer;
    logic              do_single;
    logic              do_join;
    logic              do_dup;
    logic              do_store;
    logic [DATA_W-1:0] join_l;
    logic [DATA_W-1:0] join_r;

    assign in_single = PACKET_IN[SGL_P];
    assign in_lr     = PACKET_IN[LR_P];
    assign in_tag    = PACKET_IN[TAG_L +: TAG_W];
    assign in_data   = PACKET_IN[DATA_W-1:0];

    ddp_match_cam #(
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_cam (
        .clk      (CP),
        .rst      (MR),
        .clr      (CLR),
        .lk_tag   (in_tag),
        .lk_lr    (in_lr),
        .hit      (hit),
        .dup      (dup),
        .hit_idx  (hit_idx),
        .hit_data (hit_data),
        .wr_en    (do_store),
        .wr_tag   (in_tag),
        .wr_lr    (in_lr),
        .wr_data  (in_data),
        .inv_en   (do_join),
        .inv_idx  (hit_idx)
    );

    assign out_free = !Send_out || Ack_in;

    // Dups are always absorbed so a faulty producer cannot wedge the ring.
    always_comb begin
        ack_ok = 1'b0;
        if (in_single) begin
            ack_ok = out_free;
        end else if (hit) begin
            ack_ok = out_free;
        end else if (dup) begin
            ack_ok = 1'b1;
        end else begin
            ack_ok = (OCC < FULL);
        end
    end

    assign Ack_out   = !MR && !CLR && ack_ok;
    assign xfer      = Send_in && Ack_out;
    assign do_single = xfer && in_single;
    assign do_join   = xfer && !in_single && hit;
    assign do_dup    = xfer && !in_single && dup;
    assign do_store  = xfer && !in_single && !hit && !dup && (OCC != FULL);

    assign join_l = (in_lr == LR_LEFT) ? in_data : hit_data;
    assign join_r = (in_lr == LR_LEFT) ? hit_data : in_data;

    always_ff @(posedge CP) begin
        if (MR) begin
            Send_out   <= 1'b0;
            PACKET_OUT <= '0;
            OCC        <= '0;
            ERR        <= 1'b0;
        end else begin
            if (do_single) begin
                Send_out   <= 1'b1;
                PACKET_OUT <= {1'b1, in_tag, in_data, {DATA_W{1'b0}}};
            end else if (do_join) begin
                Send_out   <= 1'b1;
                PACKET_OUT <= {1'b0, in_tag, join_l, join_r};
            end else if (Ack_in) begin
                Send_out <= 1'b0;
            end
            if (do_dup) begin
                ERR <= 1'b1;
            end
            if (CLR) begin
                OCC <= '0;
            end else if (do_join && OCC != '0) begin
                OCC <= OCC - ONE;
            end else if (do_store) begin
                OCC <= OCC + ONE;
            end
        end
    end

endmodule

// File: tb/tb_ddp_match_join.sv
// Self-checking bench for ddp_match_join: directed scenarios plus a
// randomized run against a tag-keyed behavioural model.
module tb_ddp_match_join;

    localparam int TAG_W  = 12;
    localparam int DATA_W = 24;
    localparam int DEPTH  = 8;
    localparam int PKT_W  = 2 + TAG_W + DATA_W;
    localparam int OUT_W  = 1 + TAG_W + 2 * DATA_W;
    localparam int OCC_W  = 4;

    logic             CP = 1'b0;
    logic             MR;
    logic             Send_in;
    logic             Ack_out;
    logic [PKT_W-1:0] PACKET_IN;
    logic             Send_out;
    logic             Ack_in;
    logic [OUT_W-1:0] PACKET_OUT;
    logic             CLR;
    logic [OCC_W-1:0] OCC;
    logic             ERR;

    int n_checks = 0;
    int n_fail   = 0;

    ddp_match_join #(
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .CP         (CP),
        .MR         (MR),
        .Send_in    (Send_in),
        .Ack_out    (Ack_out),
        .PACKET_IN  (PACKET_IN),
        .Send_out   (Send_out),
        .Ack_in     (Ack_in),
        .PACKET_OUT (PACKET_OUT),
        .CLR        (CLR),
        .OCC        (OCC),
        .ERR        (ERR)
    );

    always #5 CP = ~CP;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [PKT_W-1:0] mk(logic s, logic lr,
                                            logic [TAG_W-1:0] t,
                                            logic [DATA_W-1:0] d);
        return {s, lr, t, d};
    endfunction

    function automatic logic [OUT_W-1:0] mo(logic s, logic [TAG_W-1:0] t,
                                            logic [DATA_W-1:0] dl,
                                            logic [DATA_W-1:0] dr);
        return {s, t, dl, dr};
    endfunction

    task automatic tick;
        @(posedge CP);
        #1;
    endtask

    task automatic do_reset;
        MR = 1'b1; Send_in = 1'b0; CLR = 1'b0; Ack_in = 1'b1;
        PACKET_IN = '0;
        tick;
        MR = 1'b0;
        #1;
    endtask

    task automatic send(input logic [PKT_W-1:0] p);
        Send_in = 1'b1; PACKET_IN = p;
        tick;
        Send_in = 1'b0;
    endtask

    task automatic test_reset;
        MR = 1'b1; CLR = 1'b0; Ack_in = 1'b0;
        Send_in = 1'b1; PACKET_IN = mk(1'b1, 1'b0, 12'h001, 24'h1);
        #1;
        n_checks++; if (Ack_out !== 1'b0) begin n_fail++; $display("FAIL rst_ack got=%b exp=0", Ack_out); end
        tick; tick;
        n_checks++; if (Send_out !== 1'b0) begin n_fail++; $display("FAIL rst_send got=%b exp=0", Send_out); end
        n_checks++; if (PACKET_OUT !== '0) begin n_fail++; $display("FAIL rst_pkt got=%h exp=0", PACKET_OUT); end
        n_checks++; if (OCC !== 4'd0) begin n_fail++; $display("FAIL rst_occ got=%0d exp=0", OCC); end
        n_checks++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", ERR); end
        Send_in = 1'b0; MR = 1'b0;
    endtask

    task automatic test_single;
        do_reset;
        Send_in = 1'b1; PACKET_IN = mk(1'b1, 1'b1, 12'h005, 24'h000123);
        #1;
        n_checks++; if (Ack_out !== 1'b1) begin n_fail++; $display("FAIL single_ack got=%b exp=1", Ack_out); end
        tick;
        Send_in = 1'b0;
        n_checks++; if (Send_out !== 1'b1) begin n_fail++; $display("FAIL single_send got=%b exp=1", Send_out); end
        n_checks++; if (PACKET_OUT !== mo(1'b1, 12'h005, 24'h000123, 24'h0)) begin n_fail++; $display("FAIL single_pkt got=%h exp=%h", PACKET_OUT, mo(1'b1, 12'h005, 24'h000123, 24'h0)); end
        n_checks++; if (OCC !== 4'd0) begin n_fail++; $display("FAIL single_occ got=%0d exp=0", OCC); end
        tick;
        n_checks++; if (Send_out !== 1'b0) begin n_fail++; $display("FAIL single_drain got=%b exp=0", Send_out); end
    endtask

    task automatic test_pair;
        for (int k = 0; k < 2; k++) begin
            logic first_lr;
            logic [DATA_W-1:0] d1;
            logic [DATA_W-1:0] d2;
            do_reset;
            first_lr = (k == 1);
            d1 = first_lr ? 24'h22 : 24'h11;
            d2 = first_lr ? 24'h11 : 24'h22;
            send(mk(1'b0, first_lr, 12'h0A1, d1));
            n_checks++; if (OCC !== 4'd1) begin n_fail++; $display("FAIL pair_occ1[%0d] got=%0d exp=1", k, OCC); end
            n_checks++; if (Send_out !== 1'b0) begin n_fail++; $display("FAIL pair_noout[%0d] got=%b exp=0", k, Send_out); end
            send(mk(1'b0, !first_lr, 12'h0A1, d2));
            n_checks++; if (Send_out !== 1'b1) begin n_fail++; $display("FAIL pair_send[%0d] got=%b exp=1", k, Send_out); end
            n_checks++; if (PACKET_OUT !== mo(1'b0, 12'h0A1, 24'h11, 24'h22)) begin n_fail++; $display("FAIL pair_pkt[%0d] got=%h exp=%h", k, PACKET_OUT, mo(1'b0, 12'h0A1, 24'h11, 24'h22)); end
            n_checks++; if (OCC !== 4'd0) begin n_fail++; $display("FAIL pair_occ0[%0d] got=%0d exp=0", k, OCC); end
        end
    endtask

    task automatic test_full;
        do_reset;
        for (int i = 0; i < DEPTH; i++) begin
            send(mk(1'b0, 1'b0, 12'h100 + 12'(i), 24'h1000 + 24'(i)));
        end
        n_checks++; if (OCC !== 4'd8) begin n_fail++; $display("FAIL full_occ8 got=%0d exp=8", OCC); end
        Send_in = 1'b1; PACKET_IN = mk(1'b0, 1'b0, 12'h200, 24'hABC);
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++; if (Ack_out !== 1'b0) begin n_fail++; $display("FAIL full_stall[%0d] got=%b exp=0", c, Ack_out); end
            tick;
        end
        PACKET_IN = mk(1'b0, 1'b1, 12'h100, 24'h55);
        #1;
        n_checks++; if (Ack_out !== 1'b1) begin n_fail++; $display("FAIL full_hit_ack got=%b exp=1", Ack_out); end
        tick;
        n_checks++; if (OCC !== 4'd7) begin n_fail++; $display("FAIL full_occ7 got=%0d exp=7", OCC); end
        n_checks++; if (PACKET_OUT !== mo(1'b0, 12'h100, 24'h1000, 24'h55)) begin n_fail++; $display("FAIL full_pkt got=%h exp=%h", PACKET_OUT, mo(1'b0, 12'h100, 24'h1000, 24'h55)); end
        PACKET_IN = mk(1'b0, 1'b0, 12'h200, 24'hABC);
        #1;
        n_checks++; if (Ack_out !== 1'b1) begin n_fail++; $display("FAIL full_miss_ack got=%b exp=1", Ack_out); end
        tick;
        Send_in = 1'b0;
        n_checks++; if (OCC !== 4'd8) begin n_fail++; $display("FAIL full_occ8b got=%0d exp=8", OCC); end
    endtask

    task automatic test_backpressure;
        do_reset;
        Ack_in = 1'b0;
        send(mk(1'b0, 1'b0, 12'h0B0, 24'h1));
        send(mk(1'b0, 1'b1, 12'h0B0, 24'h2));
        Send_in = 1'b1; PACKET_IN = mk(1'b1, 1'b0, 12'h0C0, 24'h777);
        #1;
        n_checks++; if (Ack_out !== 1'b0) begin n_fail++; $display("FAIL bp_ack0 got=%b exp=0", Ack_out); end
        tick;
        n_checks++; if (Send_out !== 1'b1) begin n_fail++; $display("FAIL bp_hold_send got=%b exp=1", Send_out); end
        n_checks++; if (PACKET_OUT !== mo(1'b0, 12'h0B0, 24'h1, 24'h2)) begin n_fail++; $display("FAIL bp_hold_pkt got=%h exp=%h", PACKET_OUT, mo(1'b0, 12'h0B0, 24'h1, 24'h2)); end
        Ack_in = 1'b1;
        #1;
        n_checks++; if (Ack_out !== 1'b1) begin n_fail++; $display("FAIL bp_ack1 got=%b exp=1", Ack_out); end
        tick;
        Send_in = 1'b0;
        n_checks++; if (Send_out !== 1'b1) begin n_fail++; $display("FAIL bp_b2b_send got=%b exp=1", Send_out); end
        n_checks++; if (PACKET_OUT !== mo(1'b1, 12'h0C0, 24'h777, 24'h0)) begin n_fail++; $display("FAIL bp_b2b_pkt got=%h exp=%h", PACKET_OUT, mo(1'b1, 12'h0C0, 24'h777, 24'h0)); end
        tick;
        n_checks++; if (Send_out !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%b exp=0", Send_out); end
    endtask

    task automatic test_dup_reset;
        do_reset;
        send(mk(1'b0, 1'b0, 12'h0F0, 24'hA));
        Send_in = 1'b1; PACKET_IN = mk(1'b0, 1'b0, 12'h0F0, 24'hB);
        #1;
        n_checks++; if (Ack_out !== 1'b1) begin n_fail++; $display("FAIL dup_ack got=%b exp=1", Ack_out); end
        tick;
        Send_in = 1'b0;
        n_checks++; if (ERR !== 1'b1) begin n_fail++; $display("FAIL dup_err got=%b exp=1", ERR); end
        n_checks++; if (OCC !== 4'd1) begin n_fail++; $display("FAIL dup_occ got=%0d exp=1", OCC); end
        n_checks++; if (Send_out !== 1'b0) begin n_fail++; $display("FAIL dup_send got=%b exp=0", Send_out); end
        tick;
        n_checks++; if (ERR !== 1'b1) begin n_fail++; $display("FAIL dup_sticky got=%b exp=1", ERR); end
        MR = 1'b1;
        tick;
        MR = 1'b0;
        n_checks++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL dup_rst_err got=%b exp=0", ERR); end
        n_checks++; if (OCC !== 4'd0) begin n_fail++; $display("FAIL dup_rst_occ got=%0d exp=0", OCC); end
        n_checks++; if (Send_out !== 1'b0) begin n_fail++; $display("FAIL dup_rst_send got=%b exp=0", Send_out); end
    endtask

    task automatic test_clr;
        do_reset;
        Ack_in = 1'b0;
        for (int i = 0; i < 3; i++) send(mk(1'b0, 1'b0, 12'h300 + 12'(i), 24'(i)));
        send(mk(1'b1, 1'b0, 12'h0D0, 24'h999));
        n_checks++; if (OCC !== 4'd3) begin n_fail++; $display("FAIL clr_pre_occ got=%0d exp=3", OCC); end
        CLR = 1'b1; Send_in = 1'b1; PACKET_IN = mk(1'b0, 1'b1, 12'h300, 24'h5);
        #1;
        n_checks++; if (Ack_out !== 1'b0) begin n_fail++; $display("FAIL clr_ack got=%b exp=0", Ack_out); end
        tick;
        CLR = 1'b0; Send_in = 1'b0;
        n_checks++; if (OCC !== 4'd0) begin n_fail++; $display("FAIL clr_occ got=%0d exp=0", OCC); end
        n_checks++; if (Send_out !== 1'b1) begin n_fail++; $display("FAIL clr_keep_send got=%b exp=1", Send_out); end
        n_checks++; if (PACKET_OUT !== mo(1'b1, 12'h0D0, 24'h999, 24'h0)) begin n_fail++; $display("FAIL clr_keep_pkt got=%h exp=%h", PACKET_OUT, mo(1'b1, 12'h0D0, 24'h999, 24'h0)); end
        Ack_in = 1'b1;
        tick;
        n_checks++; if (Send_out !== 1'b0) begin n_fail++; $display("FAIL clr_deliver got=%b exp=0", Send_out); end
        send(mk(1'b0, 1'b1, 12'h300, 24'h5));
        n_checks++; if (OCC !== 4'd1) begin n_fail++; $display("FAIL clr_flushed got=%0d exp=1", OCC); end
        n_checks++; if (Send_out !== 1'b0) begin n_fail++; $display("FAIL clr_nomatch got=%b exp=0", Send_out); end
    endtask

    task automatic test_random;
        logic [DATA_W:0]   mw [int];
        logic              m_ov;
        logic [OUT_W-1:0]  m_op;
        logic              m_err;
        do_reset;
        m_ov = 1'b0; m_op = '0; m_err = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            logic s, sg, lr, ai, cl, fr, ex, hm, dm, eack;
            logic [TAG_W-1:0]  tg;
            logic [DATA_W-1:0] d, ed, dl, dr;
            int key;
            s  = ($urandom_range(0, 9) < 7);
            sg = ($urandom_range(0, 4) == 0);
            lr = 1'($urandom_range(0, 1));
            tg = 12'h400 + 12'($urandom_range(0, 11));
            d  = 24'($urandom);
            ai = ($urandom_range(0, 9) < 5);
            cl = ($urandom_range(0, 59) == 0);
            key = int'(tg);
            Send_in = s; PACKET_IN = mk(sg, lr, tg, d); Ack_in = ai; CLR = cl;
            fr = !m_ov || ai;
            ex = mw.exists(key);
            ed = ex ? mw[key][DATA_W-1:0] : '0;
            hm = ex && (mw[key][DATA_W] != lr);
            dm = ex && (mw[key][DATA_W] == lr);
            if (cl) eack = 1'b0;
            else if (sg || hm) eack = fr;
            else if (dm) eack = 1'b1;
            else eack = (mw.num() < DEPTH);
            #1;
            n_checks++; if (Ack_out !== eack) begin n_fail++; $display("FAIL rnd_ack[%0d] got=%b exp=%b", n, Ack_out, eack); end
            tick;
            if (m_ov && ai) m_ov = 1'b0;
            if (s && eack) begin
                if (sg) begin
                    m_op = mo(1'b1, tg, d, '0); m_ov = 1'b1;
                end else if (hm) begin
                    dl = lr ? ed : d;
                    dr = lr ? d : ed;
                    m_op = mo(1'b0, tg, dl, dr); m_ov = 1'b1;
                    mw.delete(key);
                end else if (dm) begin
                    m_err = 1'b1;
                end else begin
                    mw[key] = {lr, d};
                end
            end
            if (cl) mw.delete();
            n_checks++; if (Send_out !== m_ov) begin n_fail++; $display("FAIL rnd_send[%0d] got=%b exp=%b", n, Send_out, m_ov); end
            n_checks++; if (PACKET_OUT !== m_op) begin n_fail++; $display("FAIL rnd_pkt[%0d] got=%h exp=%h", n, PACKET_OUT, m_op); end
            n_checks++; if (OCC !== OCC_W'(mw.num())) begin n_fail++; $display("FAIL rnd_occ[%0d] got=%0d exp=%0d", n, OCC, mw.num()); end
            n_checks++; if (ERR !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d] got=%b exp=%b", n, ERR, m_err); end
        end
        Send_in = 1'b0; CLR = 1'b0;
    endtask

    initial begin
        MR = 1'b1; Send_in = 1'b0; Ack_in = 1'b0; CLR = 1'b0; PACKET_IN = '0;
        test_reset;
        test_single;
        test_pair;
        test_full;
        test_backpressure;
        test_dup_reset;
        test_clr;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
